// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: glitch-rejecting start detection, parity/framing/break flags.
// Optional macro UART_RX_MAJORITY_EN selects 2-of-3 majority voting for every bit decision.
module uart_rx_param #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD        = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 rx_valid_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 break_o,
    output logic                 busy_o
);
    localparam int DIV  = CLK_FREQ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(HALF);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE, S_BRK_WAIT
    } state_t;

    state_t                 r_state, w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_d, r_rx_d2;
    logic [CW-1:0]          r_cnt;
    logic [3:0]             r_bit_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par, r_stop0, r_ferr_acc;
    logic                   w_rx_s, w_bit, w_start_edge, w_tick, w_half, w_par_err;

    // NOTE: synchroniser flops reset to 1 so a reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '1;
            r_rx_d  <= 1'b1;
            r_rx_d2 <= 1'b1;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], rx_i};
            r_rx_d  <= w_rx_s;
            r_rx_d2 <= r_rx_d;
        end
    end

    assign w_rx_s       = r_sync[SYNC_STAGES-1];
    assign w_start_edge = r_rx_d & ~w_rx_s;
    assign w_tick       = (r_cnt == CNT_LAST);
    assign w_half       = (r_cnt == CNT_HALF);

`ifdef UART_RX_MAJORITY_EN
    assign w_bit = (w_rx_s & r_rx_d) | (w_rx_s & r_rx_d2) | (r_rx_d & r_rx_d2);
`else
    assign w_bit = w_rx_s;
`endif

    // Odd parity flags an even total of ones, even parity flags an odd total.
    assign w_par_err = (PARITY == 1) ? ~(^r_shift ^ r_par) :
                       (PARITY == 2) ?  (^r_shift ^ r_par) : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: next state defaults to the current state first, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_start_edge) w_next = S_START;
            S_START:    if (w_half) w_next = w_bit ? S_IDLE : S_DATA;
            S_DATA:     if (w_tick && r_bit_idx == LAST_DATA)
                            w_next = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY:   if (w_tick) w_next = S_STOP;
            S_STOP:     if (w_tick && r_bit_idx == LAST_STOP) w_next = S_DONE;
            S_DONE:     w_next = break_o ? S_BRK_WAIT : S_IDLE;
            S_BRK_WAIT: if (w_rx_s) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_stop0      <= 1'b0;
            r_ferr_acc   <= 1'b0;
            data_o       <= '0;
            rx_valid_o   <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            break_o      <= 1'b0;
        end else begin
            rx_valid_o <= 1'b0;
            break_o    <= 1'b0;
            case (r_state)
                S_START: r_cnt <= w_half ? '0 : r_cnt + 1'b1;
                S_DATA, S_PARITY, S_STOP: r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
                default: r_cnt <= '0;
            endcase
            if (r_state == S_IDLE) begin
                r_bit_idx  <= '0;
                r_ferr_acc <= 1'b0;
            end
            if (w_tick) begin
                case (r_state)
                    S_DATA: begin
                        r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= (r_bit_idx == LAST_DATA) ? '0 : r_bit_idx + 1'b1;
                    end
                    S_PARITY: r_par <= w_bit;
                    S_STOP: begin
                        r_bit_idx  <= r_bit_idx + 1'b1;
                        r_ferr_acc <= r_ferr_acc | ~w_bit;
                        if (r_bit_idx == '0) r_stop0 <= w_bit;
                        // Final stop sample commits the frame; outputs are live during DONE.
                        if (r_bit_idx == LAST_STOP) begin
                            data_o       <= r_shift;
                            rx_valid_o   <= 1'b1;
                            parity_err_o <= w_par_err;
                            frame_err_o  <= r_ferr_acc | ~w_bit;
                            break_o      <= (r_shift == '0) &
                                            ((r_bit_idx == '0) ? ~w_bit : ~r_stop0);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy_o = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance and an 8E2 instance driven with directed and random frames.
module tb_uart_rx_param;
    localparam int DIV = 16;

    logic clk = 1'b0, rst_n = 1'b0, rx0 = 1'b1, rx1 = 1'b1;
    logic [7:0] d0, d1;
    logic v0, pe0, fe0, br0, bz0, v1, pe1, fe1, br1, bz1;

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_FREQ(160), .BAUD(10), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                    .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .rx_i(rx0), .data_o(d0), .rx_valid_o(v0),
        .parity_err_o(pe0), .frame_err_o(fe0), .break_o(br0), .busy_o(bz0));

    uart_rx_param #(.CLK_FREQ(160), .BAUD(10), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2),
                    .SYNC_STAGES(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx_i(rx1), .data_o(d1), .rx_valid_o(v1),
        .parity_err_o(pe1), .frame_err_o(fe1), .break_o(br1), .busy_o(bz1));

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
        logic       busy_after;
    } rec_t;

    rec_t q0[$], q1[$];
    rec_t tmp0, tmp1;
    logic pend0 = 1'b0, pend1 = 1'b0;
    int   n_brk0 = 0, n_brk1 = 0, exp_brk0 = 0, exp_brk1 = 0;
    int   n_cmp = 0, n_mis = 0;

    // Capture every strobe plus the busy level one cycle later.
    always @(negedge clk) begin
        if (pend0) q0.push_back({tmp0[11:1], bz0});
        if (pend1) q1.push_back({tmp1[11:1], bz1});
        pend0 <= v0;
        pend1 <= v1;
        tmp0  <= {d0, pe0, fe0, br0, 1'b0};
        tmp1  <= {d1, pe1, fe1, br1, 1'b0};
        if (br0) n_brk0 <= n_brk0 + 1;
        if (br1) n_brk1 <= n_brk1 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input int line, input logic b, input bit glitch);
        for (int c = 0; c < DIV; c++) begin
            if (line == 0) rx0 = (glitch && (c == 6 || c == 9 || c == 12)) ? ~b : b;
            else           rx1 = b;
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input int line, input logic [7:0] data, input logic p,
                              input logic s0, input logic s1, input bit glitch);
        drive_bit(line, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(line, data[i], glitch);
        if (line == 1) drive_bit(line, p, 1'b0);
        drive_bit(line, s0, 1'b0);
        if (line == 1) drive_bit(line, s1, 1'b0);
        if (line == 0) rx0 = 1'b1; else rx1 = 1'b1;
    endtask

    function automatic rec_t model(input int line, input logic [7:0] data, input logic p,
                                   input logic s0, input logic s1);
        rec_t r;
        r.data       = data;
        r.perr       = (line == 1) ? ((($countones(data) + int'(p)) % 2) == 1) : 1'b0;
        r.ferr       = (line == 1) ? (!s0 || !s1) : !s0;
        r.brk        = (data == 8'h00) && !s0;
        r.busy_after = r.brk;
        return r;
    endfunction

    task automatic expect_rec(input int line, input rec_t e, input string tag);
        rec_t got;
        int   k = 0;
        while (((line == 0) ? q0.size() : q1.size()) == 0 && k < 4 * DIV) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        assert (((line == 0) ? q0.size() : q1.size()) != 0) else begin
            n_mis++;
            $error("FAIL %s_strobe: observed=none expected=strobe", tag);
        end
        if (((line == 0) ? q0.size() : q1.size()) != 0) begin
            got = (line == 0) ? q0.pop_front() : q1.pop_front();
            chk({tag, "_data"}, got.data, e.data);
            chk({tag, "_perr"}, got.perr, e.perr);
            chk({tag, "_ferr"}, got.ferr, e.ferr);
            chk({tag, "_brk"},  got.brk,  e.brk);
            chk({tag, "_busy"}, got.busy_after, e.busy_after);
        end
        if (e.brk) begin
            if (line == 0) exp_brk0++; else exp_brk1++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] rd;
        logic       rp, rs0, rs1;
        bit         busy_seen;

        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rd;
        logic       rp, rs0, rs1;
        bit         busy_seen;

        // Reset state
        idle(3);
        chk("rst_valid", {v0, v1}, 2'b00);
        chk("rst_data", {d0, d1}, 16'h0000);
        chk("rst_flags", {pe0, fe0, br0, pe1, fe1, br1}, 6'b0);
        chk("rst_busy", {bz0, bz1}, 2'b00);
        rst_n = 1'b1;
        idle(2 * DIV);

        // Basic 8N1 frame
        send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_rec(0, model(0, 8'hA5, 1'b0, 1'b1, 1'b1), "a5");
        idle(DIV);

        // Short start glitch
        busy_seen = 1'b0;
        rx0 = 1'b0;
        for (int i = 0; i < 3 * DIV; i++) begin
            if (i == 3) rx0 = 1'b1;
            if (bz0) busy_seen = 1'b1;
            @(negedge clk);
        end
        chk("glitch_busy_seen", busy_seen, 1'b1);
        chk("glitch_busy_end", bz0, 1'b0);
        chk("glitch_nostrobe", q0.size(), 0);
        send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_rec(0, model(0, 8'h3C, 1'b0, 1'b1, 1'b1), "after_glitch");
        idle(DIV);

        // Even parity
        send_frame(1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_rec(1, model(1, 8'h07, 1'b0, 1'b1, 1'b1), "par_bad");
        idle(DIV);
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
        expect_rec(1, model(1, 8'h07, 1'b1, 1'b1, 1'b1), "par_ok");
        idle(DIV);

        // Framing error
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_rec(0, model(0, 8'h3C, 1'b0, 1'b0, 1'b1), "frame_err");
        idle(2 * DIV);

        // Break: line low for 20 bit times
        rx0 = 1'b0;
        idle(20 * DIV);
        expect_rec(0, model(0, 8'h00, 1'b0, 1'b0, 1'b1), "break");
        chk("break_no_more", q0.size(), 0);
        chk("break_wait_busy", bz0, 1'b1);
        rx0 = 1'b1;
        idle(2 * DIV);
        chk("break_release_busy", bz0, 1'b0);
        send_frame(0, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_rec(0, model(0, 8'h81, 1'b0, 1'b1, 1'b1), "after_break");

        // Back-to-back with no idle
        send_frame(0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_rec(0, model(0, 8'h55, 1'b0, 1'b1, 1'b1), "b2b_55");
        send_frame(0, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_rec(0, model(0, 8'hAA, 1'b0, 1'b1, 1'b1), "b2b_aa");
        idle(DIV);

        // Reset in the middle of a byte
        rx0 = 1'b0;
        idle(3 * DIV);
        rx0 = 1'b1;
        idle(DIV);
        rst_n = 1'b0;
        idle(1);
        chk("midrst_outputs", {d0, v0, pe0, fe0, br0, bz0}, 13'h0);
        idle(2);
        rst_n = 1'b1;
        idle(12 * DIV);
        chk("midrst_nostrobe", q0.size(), 0);
        chk("midrst_busy", bz0, 1'b0);

        // Random 8N1 frames
        for (int n = 0; n < 12; n++) begin
            rd  = 8'($urandom);
            rs0 = ($urandom_range(0, 3) != 0);
            send_frame(0, rd, 1'b0, rs0, 1'b1, 1'b0);
            expect_rec(0, model(0, rd, 1'b0, rs0, 1'b1), "rnd0");
            idle(rs0 ? $urandom_range(0, DIV) : $urandom_range(2, DIV));
        end

        // Random 8E2 frames
        for (int n = 0; n < 12; n++) begin
            rd  = (n == 5) ? 8'h00 : 8'($urandom);
            rp  = 1'($urandom);
            rs0 = (n == 5) ? 1'b0 : ($urandom_range(0, 3) != 0);
            rs1 = ($urandom_range(0, 3) != 0);
            send_frame(1, rd, rp, rs0, rs1, 1'b0);
            expect_rec(1, model(1, rd, rp, rs0, rs1), "rnd1");
            idle($urandom_range(2, DIV));
        end

`ifdef UART_RX_MAJORITY_EN
        send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b1);
        expect_rec(0, model(0, 8'h5A, 1'b0, 1'b1, 1'b1), "majority");
        idle(DIV);
`endif

        idle(4 * DIV);
        chk("no_stray_strobes", q0.size() + q1.size(), 0);
        chk("break_count0", n_brk0, exp_brk0);
        chk("break_count1", n_brk1, exp_brk1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
